// File: rtl/egress_port_if.sv
// Core-to-egress bus of a switch port: packet words in from the core, framed
// words out to the egress sink. master = core/sink side, slave = egress_port.
interface egress_port_if;
  logic        pkt_vld;
  logic [15:0] pkt_data;
  logic        pkt_last;
  logic        xfer_stop;
  logic        tx_pause;
  logic        tx_sop;
  logic        tx_vld;
  logic [15:0] tx_data;
  logic        tx_eop;
  logic [3:0]  tx_dest;
  logic [8:0]  tx_length;

  modport master (
    output pkt_vld, pkt_data, pkt_last, tx_pause,
    input  xfer_stop, tx_sop, tx_vld, tx_data, tx_eop, tx_dest, tx_length
  );

  modport slave (
    input  pkt_vld, pkt_data, pkt_last, tx_pause,
    output xfer_stop, tx_sop, tx_vld, tx_data, tx_eop, tx_dest, tx_length
  );
endinterface

// File: rtl/egress_port.sv
// Store-and-forward egress transmitter: buffers whole packets in a FIFO and
// replays each one framed as sop pulse, vld words, eop pulse.
module egress_port #(
  parameter int DEPTH       = 64,
  parameter int AW          = 6,
  parameter int STOP_MARGIN = 4
) (
  input  logic         clk,
  input  logic         rst,
  egress_port_if.slave bus,
  output logic         o_ovf
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SOP  = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;
  localparam logic [1:0] S_EOP  = 2'd3;

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW:0] STOP_W  = (AW+1)'(STOP_MARGIN);

  // Entry = {last marker, word}.
  logic [16:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr, r_pkt_start;
  logic [AW:0]   r_fill, r_pkt_words, r_pkt_cnt;
  logic          r_bad, r_ovf, r_xfer_stop;
  logic [1:0]    r_state;
  logic          r_tx_sop, r_tx_vld, r_tx_eop;
  logic [15:0]   r_tx_data;
  logic [3:0]    r_tx_dest;
  logic [8:0]    r_tx_length;

  logic          w_full, w_push, w_drop, w_rollback, w_commit;
  logic          w_pop, w_eop;
  logic [16:0]   w_rd_word;
  logic [AW:0]   w_fill_nxt, w_pkt_cnt_nxt;

  assign w_full     = (r_fill == DEPTH_W);
  assign w_push     = bus.pkt_vld && !r_bad && !w_full;
  assign w_drop     = bus.pkt_vld && !r_bad && w_full;
  // A packet that lost any word is unwound entirely when its last word shows up.
  assign w_rollback = bus.pkt_vld && bus.pkt_last && (r_bad || w_full);
  assign w_commit   = w_push && bus.pkt_last;

  assign w_rd_word  = r_mem[r_rd_ptr];
  assign w_pop      = (r_state == S_DATA) && !bus.tx_pause;
  assign w_eop      = (r_state == S_EOP);

  assign w_fill_nxt    = r_fill + (AW+1)'(w_push) - (AW+1)'(w_pop)
                       - (w_rollback ? r_pkt_words : '0);
  assign w_pkt_cnt_nxt = r_pkt_cnt + (AW+1)'(w_commit) - (AW+1)'(w_eop);

  // NOTE: storage array has no reset; its contents are never read before written.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {bus.pkt_last, bus.pkt_data};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_pkt_start <= '0;
      r_fill      <= '0;
      r_pkt_words <= '0;
      r_pkt_cnt   <= '0;
      r_bad       <= 1'b0;
      r_ovf       <= 1'b0;
      r_xfer_stop <= 1'b0;
      r_state     <= S_IDLE;
      r_tx_sop    <= 1'b0;
      r_tx_vld    <= 1'b0;
      r_tx_eop    <= 1'b0;
      r_tx_data   <= '0;
      r_tx_dest   <= '0;
      r_tx_length <= '0;
    end else begin
      r_fill      <= w_fill_nxt;
      r_pkt_cnt   <= w_pkt_cnt_nxt;
      r_xfer_stop <= (DEPTH_W - r_fill) <= STOP_W;
      r_ovf       <= r_ovf | w_drop;

      if (w_rollback) begin
        r_wr_ptr    <= r_pkt_start;
        r_pkt_words <= '0;
        r_bad       <= 1'b0;
      end else if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
        if (bus.pkt_last) begin
          r_pkt_start <= r_wr_ptr + 1'b1;
          r_pkt_words <= '0;
        end else begin
          r_pkt_words <= r_pkt_words + 1'b1;
        end
      end else if (w_drop) begin
        r_bad <= 1'b1;
      end

      // NOTE: non-blocking defaults make the pulses one cycle wide; a later
      // assignment in the same block wins.
      r_tx_sop <= 1'b0;
      r_tx_vld <= 1'b0;
      r_tx_eop <= 1'b0;
      case (r_state)
        S_IDLE: if (r_pkt_cnt != '0 && !bus.tx_pause) r_state <= S_SOP;
        S_SOP: begin
          r_tx_sop    <= 1'b1;
          r_tx_dest   <= w_rd_word[3:0];
          r_tx_length <= w_rd_word[15:7];
          r_state     <= S_DATA;
        end
        S_DATA: if (!bus.tx_pause) begin
          r_tx_vld  <= 1'b1;
          r_tx_data <= w_rd_word[15:0];
          r_rd_ptr  <= r_rd_ptr + 1'b1;
          if (w_rd_word[16]) r_state <= S_EOP;
        end
        S_EOP: begin
          r_tx_eop <= 1'b1;
          r_state  <= (w_pkt_cnt_nxt != '0 && !bus.tx_pause) ? S_SOP : S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.xfer_stop = r_xfer_stop;
  assign bus.tx_sop    = r_tx_sop;
  assign bus.tx_vld    = r_tx_vld;
  assign bus.tx_data   = r_tx_data;
  assign bus.tx_eop    = r_tx_eop;
  assign bus.tx_dest   = r_tx_dest;
  assign bus.tx_length = r_tx_length;
  assign o_ovf         = r_ovf;

endmodule

// File: tb/tb_egress_port.sv
// Directed bench for egress_port: framing, latency, pause, overflow, wrap and
// mid-packet reset, with hand-computed expected words.
module tb_egress_port;
  logic clk = 1'b0;
  logic rst;
  logic ovf;

  egress_port_if bus();

  egress_port #(.DEPTH(64), .AW(6), .STOP_MARGIN(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .o_ovf (ovf)
  );

  always #5 clk = ~clk;

  localparam logic [15:0] T1 [5] = '{16'h0283, 16'h0001, 16'h0002, 16'h0003, 16'h0004};
  localparam logic [15:0] T2 [6] = '{16'h0185, 16'h0A01, 16'h0A02,
                                     16'h0189, 16'h0B01, 16'h0B02};
  localparam logic [15:0] T3 [6] = '{16'h0302, 16'h3001, 16'h3002,
                                     16'h3003, 16'h3004, 16'h3005};

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Egress monitor, sampled on the falling edge.
  logic [15:0] rx_q [$];
  logic [15:0] exp_q [$];
  int   n_sop = 0, n_eop = 0, n_e2s = 0, frame_gap = 0, last_gap = 0;
  logic prev_eop = 1'b0, in_frame = 1'b0;
  bit   push_done;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.tx_vld) rx_q.push_back(bus.tx_data);
      if (bus.tx_sop) begin
        n_sop++;
        frame_gap = 0;
        in_frame  = 1'b1;
        if (prev_eop) n_e2s++;
      end else if (in_frame && !bus.tx_vld && !bus.tx_eop) begin
        frame_gap++;
      end
      if (bus.tx_eop) begin
        n_eop++;
        last_gap = frame_gap;
        in_frame = 1'b0;
      end
      prev_eop = bus.tx_eop;
    end else begin
      prev_eop = 1'b0;
      in_frame = 1'b0;
    end
  end

  function automatic logic [15:0] rx_at(input int idx);
    if (idx < rx_q.size()) return rx_q[idx];
    return 16'hDEAD;
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic align();
    @(posedge clk);
    #1;
  endtask

  // Called #1 after a rising edge; returns #1 after the edge that accepted the word.
  task automatic push(input logic [15:0] d, input logic last);
    bus.pkt_vld  = 1'b1;
    bus.pkt_data = d;
    bus.pkt_last = last;
    @(posedge clk);
    #1;
    bus.pkt_vld  = 1'b0;
    bus.pkt_last = 1'b0;
  endtask

  task automatic wait_eop(input int target, input int budget, input string tag);
    int k = 0;
    while (n_eop < target && k < budget) begin
      tick();
      k++;
    end
    check(tag, n_eop, target);
  endtask

  task automatic wait_rx(input int target, input int budget, input string tag);
    int k = 0;
    while (rx_q.size() < target && k < budget) begin
      tick();
      k++;
    end
    check(tag, rx_q.size(), target);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ctl"},  {bus.tx_sop, bus.tx_vld, bus.tx_eop, ovf, bus.xfer_stop}, 0);
    check({tag, "_data"}, bus.tx_data, 0);
    check({tag, "_desc"}, {bus.tx_dest, bus.tx_length}, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_rx, base_eop, base_sop, base_e2s;
    logic [15:0] w;

    bus.pkt_vld  = 1'b0;
    bus.pkt_data = '0;
    bus.pkt_last = 1'b0;
    bus.tx_pause = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    tick();
    check_idle_outputs("reset");

    // 1: single packet, cycle-exact framing and descriptor
    align();
    for (int i = 0; i < 5; i++) push(T1[i], i == 4);
    tick();
    check("t1_sop_early0", bus.tx_sop, 0);
    tick();
    check("t1_sop_early1", bus.tx_sop, 0);
    tick();
    check("t1_sop", {bus.tx_sop, bus.tx_vld}, 2'b10);
    check("t1_dest", bus.tx_dest, 4'd3);
    check("t1_length", bus.tx_length, 9'd5);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t1_vld", {bus.tx_sop, bus.tx_vld, bus.tx_eop}, 3'b010);
      check("t1_data", bus.tx_data, T1[i]);
    end
    tick();
    check("t1_eop", {bus.tx_sop, bus.tx_vld, bus.tx_eop}, 3'b001);
    tick();
    check("t1_after", {bus.tx_sop, bus.tx_vld, bus.tx_eop}, 3'b000);
    check("t1_dest_hold", bus.tx_dest, 4'd3);

    // 2: back-to-back 3-word packets
    align();
    base_rx = rx_q.size(); base_eop = n_eop; base_e2s = n_e2s;
    for (int i = 0; i < 6; i++) push(T2[i], i == 2 || i == 5);
    wait_eop(base_eop + 2, 60, "t2_frames");
    check("t2_words", rx_q.size() - base_rx, 6);
    for (int i = 0; i < 6; i++) check("t2_data", rx_at(base_rx + i), T2[i]);
    check("t2_eop_to_sop", n_e2s - base_e2s, 1);
    check("t2_pkt_cnt", dut.r_pkt_cnt, 0);
    check("t2_desc", {bus.tx_dest, bus.tx_length}, {4'd9, 9'd3});

    // 3a: 3-cycle pause after the second data word
    align();
    base_rx = rx_q.size(); base_eop = n_eop;
    for (int i = 0; i < 6; i++) push(T3[i], i == 5);
    wait_rx(base_rx + 2, 40, "t3_two_words");
    bus.tx_pause = 1'b1;
    repeat (3) tick();
    bus.tx_pause = 1'b0;
    wait_eop(base_eop + 1, 40, "t3_frame");
    check("t3_gap", last_gap, 3);
    check("t3_words", rx_q.size() - base_rx, 6);
    for (int i = 0; i < 6; i++) check("t3_data", rx_at(base_rx + i), T3[i]);

    // 3b: pause during SOP, 1-word packet
    align();
    base_rx = rx_q.size(); base_eop = n_eop;
    push(16'h008F, 1'b1);
    align();
    bus.tx_pause = 1'b1;
    tick();
    tick();
    check("t3_sop_paused", bus.tx_sop, 1);
    bus.tx_pause = 1'b0;
    wait_eop(base_eop + 1, 20, "t3_one_word_frame");
    check("t3_one_word_cnt", rx_q.size() - base_rx, 1);
    check("t3_one_word", rx_at(base_rx), 16'h008F);
    check("t3_one_desc", {bus.tx_dest, bus.tx_length}, {4'hF, 9'd1});

    // 4: exact-fit 64-word packet, then a 65-word overflow
    align();
    base_rx = rx_q.size(); base_eop = n_eop;
    for (int i = 0; i < 64; i++) begin
      w = (i == 0) ? 16'h2001 : 16'h4000 + 16'(i);
      push(w, i == 63);
      if (i == 59) check("t4_stop_at60", bus.xfer_stop, 0);
      if (i == 60) check("t4_stop_at61", bus.xfer_stop, 1);
    end
    check("t4_no_ovf", ovf, 0);
    wait_eop(base_eop + 1, 200, "t4_full_frame");
    check("t4_words", rx_q.size() - base_rx, 64);
    for (int i = 0; i < 64; i++)
      check("t4_data", rx_at(base_rx + i), (i == 0) ? 16'h2001 : 16'h4000 + 16'(i));
    check("t4_no_ovf_after", ovf, 0);
    check("t4_stop_drained", bus.xfer_stop, 0);

    align();
    base_rx = rx_q.size(); base_eop = n_eop; base_sop = n_sop;
    for (int i = 0; i < 65; i++) push((i == 0) ? 16'h2082 : 16'h7000 + 16'(i), i == 64);
    check("t4_ovf", ovf, 1);
    repeat (10) tick();
    check("t4_bad_not_sent", n_sop - base_sop, 0);
    align();
    push(16'h0184, 1'b0);
    push(16'h5001, 1'b0);
    push(16'h5002, 1'b1);
    wait_eop(base_eop + 1, 30, "t4_good_frame");
    check("t4_good_words", rx_q.size() - base_rx, 3);
    check("t4_good_w0", rx_at(base_rx),     16'h0184);
    check("t4_good_w1", rx_at(base_rx + 1), 16'h5001);
    check("t4_good_w2", rx_at(base_rx + 2), 16'h5002);
    check("t4_good_dest", bus.tx_dest, 4'd4);

    // 5: 20 x 7-word packets across pointer wrap, random sink pause
    align();
    base_rx = rx_q.size(); base_eop = n_eop;
    exp_q.delete();
    push_done = 1'b0;
    fork
      begin
        for (int p = 0; p < 20; p++) begin
          for (int i = 0; i < 7; i++) begin
            int g = 0;
            while (bus.xfer_stop && g < 500) begin
              align();
              g++;
            end
            w = (i == 0) ? {9'd7, 3'd0, 4'(p)} : {8'(p), 8'(i)};
            exp_q.push_back(w);
            push(w, i == 6);
          end
        end
        push_done = 1'b1;
      end
      begin
        while (!push_done) begin
          align();
          bus.tx_pause = ($urandom_range(0, 3) == 0);
        end
      end
    join
    bus.tx_pause = 1'b0;
    wait_eop(base_eop + 20, 800, "t5_frames");
    check("t5_words", rx_q.size() - base_rx, 140);
    for (int i = 0; i < 140; i++) check("t5_data", rx_at(base_rx + i), exp_q[i]);
    check("t5_ovf_sticky", ovf, 1);

    // 6: reset during DATA of a 10-word packet
    align();
    base_rx = rx_q.size();
    for (int i = 0; i < 10; i++) push((i == 0) ? 16'h0508 : 16'h8000 + 16'(i), i == 9);
    wait_rx(base_rx + 4, 40, "t6_mid_packet");
    base_eop = n_eop; base_sop = n_sop;
    rst = 1'b1;
    align();
    rst = 1'b0;
    tick();
    check_idle_outputs("t6_reset");
    repeat (15) tick();
    check("t6_no_eop", n_eop - base_eop, 0);
    check("t6_no_sop", n_sop - base_sop, 0);
    align();
    base_rx = rx_q.size();
    push(16'h0106, 1'b0);
    push(16'h6001, 1'b1);
    wait_eop(base_eop + 1, 30, "t6_clean_frame");
    check("t6_words", rx_q.size() - base_rx, 2);
    check("t6_w0", rx_at(base_rx),     16'h0106);
    check("t6_w1", rx_at(base_rx + 1), 16'h6001);
    check("t6_desc", {bus.tx_dest, bus.tx_length}, {4'd6, 9'd2});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
